// File: rtl/cpu_pkg.sv
// Package for the instruction execution unit that feeds the LCD controller.
// Contents: opcode and FSM state enums, instruction field bit positions,
// saturation limit, and helpers for saturation and magnitude extraction.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADDI = 3'd2,
    OP_SUB  = 3'd3,
    OP_SUBI = 3'd4,
    OP_MUL  = 3'd5,
    OP_CLR  = 3'd6,
    OP_DPL  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_CLR_LOOP,
    S_WB,
    S_NOTIFY
  } state_e;

  // Instruction field positions; the imm sign bit overlays rs2[3].
  localparam int unsigned OP_MSB   = 17;
  localparam int unsigned OP_LSB   = 15;
  localparam int unsigned RD_MSB   = 14;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned RS1_MSB  = 10;
  localparam int unsigned RS1_LSB  = 7;
  localparam int unsigned RS2_MSB  = 6;
  localparam int unsigned RS2_LSB  = 3;
  localparam int unsigned IMM_SIGN = 6;
  localparam int unsigned IMM_MSB  = 5;

  localparam logic signed [15:0] SAT_MAX = 16'sd32767;

  // Clamp to the symmetric range so -32768 never reaches memory.
  function automatic logic signed [15:0] saturate(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return SAT_MAX;
    else if (v < -33'sd32767)
      return -SAT_MAX;
    else
      return v[15:0];
  endfunction

  function automatic logic [14:0] magnitude(input logic signed [15:0] v);
    return 15'(v[15] ? -v : v);
  endfunction

endpackage

// File: rtl/cpu_exec_unit_debouncer.sv
// button_debouncer: synchronises an asynchronous active-low key, accepts a new
// level only after it has been stable for DEBOUNCE_CYCLES cycles, and emits a
// one-cycle press strobe on each accepted falling edge.
// Ports: clk, rst (async, active-high), button_n (raw key),
//        level (debounced level, 1 = released), press (one-cycle strobe).
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], button_n};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          press <= ~sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// cpu_exec_unit: executes one 18-bit instruction per debounced key press on a
// 16x16 signed register memory and reports the result to the LCD controller.
// Ports: clk, rst (async, active-high), on_off (press enable), enviar_n (raw
//        key), instr (op/rd/rs1/rs2/imm); outputs last_oppcode_opperation,
//        addr, sig, number (sign-magnitude result), lcd_enviar (active-low
//        notify pulse), busy (FSM not idle).
module cpu_exec_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PULSE_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on_off,
  input  logic        enviar_n,
  input  logic [17:0] instr,
  output logic [2:0]  last_oppcode_opperation,
  output logic [3:0]  addr,
  output logic        sig,
  output logic [14:0] number,
  output logic        lcd_enviar,
  output logic        busy
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

  logic                level;
  logic                press;
  state_e              state;
  logic [17:0]         ir;
  logic signed [15:0]  mem [16];
  logic signed [15:0]  a_q, b_q, result_q;
  logic [3:0]          clr_idx;
  logic [PW-1:0]       pcnt;

  op_e                 op;
  logic [3:0]          rd, rs1, rs2;
  logic signed [15:0]  imm;
  logic signed [32:0]  a_ext, b_ext, imm_ext, alu_wide;
  logic signed [31:0]  a32, b32, prod;
  logic signed [15:0]  wb_val;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .button_n (enviar_n),
    .level    (level),
    .press    (press)
  );

  assign op      = op_e'(ir[OP_MSB:OP_LSB]);
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs1     = ir[RS1_MSB:RS1_LSB];
  assign rs2     = ir[RS2_MSB:RS2_LSB];
  assign imm     = ir[IMM_SIGN] ? -{10'b0, ir[IMM_MSB:0]} : {10'b0, ir[IMM_MSB:0]};
  assign a_ext   = {{17{a_q[15]}}, a_q};
  assign b_ext   = {{17{b_q[15]}}, b_q};
  assign imm_ext = {{17{imm[15]}}, imm};
  assign a32     = {{16{a_q[15]}}, a_q};
  assign b32     = {{16{b_q[15]}}, b_q};
  assign prod    = a32 * b32;
  // DPL shows the word fetched in RD_A; every other op shows the EXEC result.
  assign wb_val  = (op == OP_DPL) ? a_q : result_q;
  assign busy    = (state != S_IDLE);

  always_comb begin
    alu_wide = '0;
    unique case (op)
      OP_LOAD: alu_wide = imm_ext;
      OP_ADD:  alu_wide = a_ext + b_ext;
      OP_ADDI: alu_wide = a_ext + imm_ext;
      OP_SUB:  alu_wide = a_ext - b_ext;
      OP_SUBI: alu_wide = a_ext - imm_ext;
      OP_MUL:  alu_wide = {prod[31], prod};
      default: alu_wide = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= S_IDLE;
      ir                      <= '0;
      a_q                     <= '0;
      b_q                     <= '0;
      result_q                <= '0;
      clr_idx                 <= '0;
      pcnt                    <= '0;
      last_oppcode_opperation <= '0;
      addr                    <= '0;
      sig                     <= 1'b0;
      number                  <= '0;
      lcd_enviar              <= 1'b1;
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (press && !level && on_off) state <= S_LATCH;
        end
        S_LATCH: begin
          ir      <= instr;
          clr_idx <= '0;
          unique case (op_e'(instr[OP_MSB:OP_LSB]))
            OP_LOAD: state <= S_EXEC;
            OP_CLR:  state <= S_CLR_LOOP;
            default: state <= S_RD_A;
          endcase
        end
        S_RD_A: begin
          if (op == OP_DPL) begin
            a_q   <= mem[rd];
            state <= S_WB;
          end else begin
            a_q   <= mem[rs1];
            state <= S_RD_B;
          end
        end
        S_RD_B: begin
          b_q   <= mem[rs2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= saturate(alu_wide);
          state    <= S_WB;
        end
        S_CLR_LOOP: begin
          mem[clr_idx] <= '0;
          clr_idx      <= clr_idx + 4'd1;
          if (clr_idx == 4'd15) begin
            result_q <= '0;
            state    <= S_WB;
          end
        end
        S_WB: begin
          if (op != OP_DPL && op != OP_CLR) mem[rd] <= result_q;
          last_oppcode_opperation <= ir[OP_MSB:OP_LSB];
          addr                    <= (op == OP_CLR) ? 4'd0 : rd;
          sig                     <= wb_val[15];
          number                  <= magnitude(wb_val);
          lcd_enviar              <= 1'b0;
          pcnt                    <= '0;
          state                   <= S_NOTIFY;
        end
        S_NOTIFY: begin
          if (pcnt == PW'(PULSE_CYCLES - 1)) begin
            lcd_enviar <= 1'b1;
            state      <= S_IDLE;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_exec_unit.sv
module tb_cpu_exec_unit;

  logic        clk;
  logic        rst;
  logic        on_off;
  logic        enviar_n;
  logic [17:0] instr;
  logic [2:0]  last_oppcode_opperation;
  logic [3:0]  addr;
  logic        sig;
  logic [14:0] number;
  logic        lcd_enviar;
  logic        busy;

  cpu_exec_unit #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .on_off                  (on_off),
    .enviar_n                (enviar_n),
    .instr                   (instr),
    .last_oppcode_opperation (last_oppcode_opperation),
    .addr                    (addr),
    .sig                     (sig),
    .number                  (number),
    .lcd_enviar              (lcd_enviar),
    .busy                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic        sig;
    logic [14:0] num;
    int          lat;
  } exp_t;

  typedef struct {
    logic [17:0] instr;
    exp_t        exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   falls  = 0;
  exp_t sbq[$];
  vec_t vecs[$];

  // ---------------- encoders ----------------
  function automatic logic [17:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {op[2:0], rd[3:0], rs1[3:0], rs2[3:0], 3'b000};
  endfunction

  function automatic logic [17:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    logic [5:0] mag;
    logic       s;
    s   = (imm < 0);
    mag = s ? 6'(-imm) : 6'(imm);
    return {op[2:0], rd[3:0], rs1[3:0], s, mag};
  endfunction

  function automatic int lat_of(input int op);
    if (op == 0 || op == 7) return 2;
    if (op == 6) return 17;
    return 4;
  endfunction

  function automatic exp_t mk(input int op, input int a, input int s, input int n);
    exp_t e;
    e.op   = op[2:0];
    e.addr = a[3:0];
    e.sig  = s[0];
    e.num  = n[14:0];
    e.lat  = lat_of(op);
    return e;
  endfunction

  task automatic add_r(input int op, input int rd, input int rs1, input int rs2,
                       input int ea, input int es, input int en);
    vec_t v;
    v.instr = enc_r(op, rd, rs1, rs2);
    v.exp   = mk(op, ea, es, en);
    vecs.push_back(v);
  endtask

  task automatic add_i(input int op, input int rd, input int rs1, input int imm,
                       input int ea, input int es, input int en);
    vec_t v;
    v.instr = enc_i(op, rd, rs1, imm);
    v.exp   = mk(op, ea, es, en);
    vecs.push_back(v);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  int   bcnt = 0;
  int   low_cnt = 0;
  logic prev_lcd = 1'b1;
  logic prev_busy = 1'b0;
  exp_t got;

  always @(negedge clk) begin
    if (rst) begin
      bcnt      = 0;
      low_cnt   = 0;
      prev_lcd  = 1'b1;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) bcnt = 1;
      else if (busy) bcnt++;
      if (!lcd_enviar && prev_lcd) begin
        falls++;
        low_cnt = 1;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL notify_unexpected op=%0d addr=%0d num=%0d", last_oppcode_opperation, addr, number);
        end else begin
          got = sbq.pop_front();
          if (last_oppcode_opperation !== got.op || addr !== got.addr ||
              sig !== got.sig || number !== got.num) begin
            errors++;
            $display("FAIL wb_outputs got op=%0d addr=%0d sig=%0d num=%0d expected op=%0d addr=%0d sig=%0d num=%0d",
                     last_oppcode_opperation, addr, sig, number, got.op, got.addr, got.sig, got.num);
          end
          checks++;
          if (bcnt - 2 != got.lat) begin
            errors++;
            $display("FAIL latency got=%0d expected=%0d (op=%0d)", bcnt - 2, got.lat, got.op);
          end
        end
      end else if (!lcd_enviar) begin
        low_cnt++;
      end
      if (lcd_enviar && !prev_lcd) begin
        checks++;
        if (low_cnt != 4 || busy) begin
          errors++;
          $display("FAIL notify_pulse low_cycles=%0d busy=%0d expected 4 cycles, busy=0", low_cnt, busy);
        end
      end
      prev_lcd  = lcd_enviar;
      prev_busy = busy;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL press_accept busy=%0d expected 1 within 50 cycles", busy);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL return_idle busy=%0d expected 0 within 100 cycles", busy);
    end
  endtask

  task automatic press_and_wait(input logic [17:0] ins);
    instr    = ins;
    enviar_n = 1'b0;
    wait_busy();
    repeat (3) @(negedge clk);
    enviar_n = 1'b1;
    wait_idle();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (last_oppcode_opperation !== 3'd0 || addr !== 4'd0 || sig !== 1'b0 ||
        number !== 15'd0 || lcd_enviar !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s got op=%0d addr=%0d sig=%0d num=%0d lcd=%0d busy=%0d expected 0 0 0 0 1 0",
               name, last_oppcode_opperation, addr, sig, number, lcd_enviar, busy);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int f0;
    int busy_seen;

    // op rd rs1 rs2/imm -> addr sig number
    add_i(0, 3, 0, -5,    3, 1, 5);
    add_i(0, 1, 0, 50,    1, 0, 50);
    add_r(5, 2, 1, 1,     2, 0, 2500);
    add_i(0, 3, 0, 12,    3, 0, 12);
    add_r(5, 1, 2, 3,     1, 0, 30000);
    add_i(0, 4, 0, 4,     4, 0, 4);
    add_r(5, 2, 2, 4,     2, 0, 10000);
    add_r(1, 4, 1, 2,     4, 0, 32767);
    add_i(0, 1, 0, -50,   1, 1, 50);
    add_i(0, 3, 0, 4,     3, 0, 4);
    add_r(5, 1, 1, 3,     1, 1, 200);
    add_i(0, 2, 0, 60,    2, 0, 60);
    add_i(0, 5, 0, 5,     5, 0, 5);
    add_r(5, 2, 2, 5,     2, 0, 300);
    add_r(5, 5, 1, 2,     5, 1, 32767);
    add_i(4, 6, 2, 45,    6, 0, 255);
    add_r(3, 7, 1, 2,     7, 1, 500);
    add_r(3, 8, 5, 4,     8, 1, 32767);
    add_i(2, 9, 3, -4,    9, 0, 0);
    add_r(7, 5, 0, 0,     5, 1, 32767);
    add_r(1, 1, 1, 1,     1, 1, 400);
    add_i(4, 10, 8, 63,   10, 1, 32767);
    add_i(2, 11, 6, -63,  11, 0, 192);
    add_r(6, 9, 0, 0,     0, 0, 0);
    for (int i = 0; i < 16; i++) add_r(7, i, 0, 0, i, 0, 0);

    rst      = 1'b1;
    on_off   = 1'b1;
    enviar_n = 1'b1;
    instr    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");

    for (int i = 0; i < vecs.size(); i++) begin
      sbq.push_back(vecs[i].exp);
      press_and_wait(vecs[i].instr);
    end

    // bouncing key: one execution only
    f0 = falls;
    sbq.push_back(mk(0, 11, 0, 7));
    instr = enc_i(0, 11, 0, 7);
    for (int i = 0; i < 10; i++) begin
      enviar_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    enviar_n = 1'b0;
    wait_busy();
    repeat (3) @(negedge clk);
    enviar_n = 1'b1;
    wait_idle();
    repeat (8) @(negedge clk);
    check_val("bounce_exec_count", falls - f0, 1);

    // second press while busy (CLR is long) is dropped
    f0 = falls;
    sbq.push_back(mk(6, 0, 0, 0));
    instr    = enc_r(6, 3, 0, 0);
    enviar_n = 1'b0;
    wait_busy();
    enviar_n = 1'b1;
    repeat (8) @(negedge clk);
    instr    = enc_i(0, 12, 0, 33);
    enviar_n = 1'b0;
    repeat (8) @(negedge clk);
    enviar_n = 1'b1;
    wait_idle();
    repeat (30) @(negedge clk);
    check_val("busy_press_exec_count", falls - f0, 1);
    check_val("busy_press_no_requeue", busy, 0);

    // on_off=0: press ignored
    f0 = falls;
    busy_seen = 0;
    on_off   = 1'b0;
    instr    = enc_i(0, 13, 0, 9);
    enviar_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy || !lcd_enviar) busy_seen++;
    end
    enviar_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("off_no_busy", busy_seen, 0);
    check_val("off_no_notify", falls - f0, 0);
    check_val("off_number_kept", number, 0);
    on_off = 1'b1;

    // on_off dropped mid-operation: still completes
    sbq.push_back(mk(4, 13, 1, 7));
    instr    = enc_i(4, 13, 0, 7);
    enviar_n = 1'b0;
    wait_busy();
    on_off = 1'b0;
    repeat (3) @(negedge clk);
    enviar_n = 1'b1;
    wait_idle();
    repeat (8) @(negedge clk);
    on_off = 1'b1;

    // reset during CLR_LOOP
    sbq.push_back(mk(0, 2, 0, 9));
    press_and_wait(enc_i(0, 2, 0, 9));
    instr    = enc_r(6, 0, 0, 0);
    enviar_n = 1'b0;
    wait_busy();
    repeat (6) @(negedge clk);
    rst      = 1'b1;
    enviar_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_clr");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_outputs("after_reset_idle");
    sbq.push_back(mk(7, 2, 0, 0));
    press_and_wait(enc_r(7, 2, 0, 0));

    check_val("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
